// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32 ALU/load/store instructions into an alu_op plus two operands,
// registered through a 2-entry (output + skid) buffer. Optional BEQ decode: ALU_BRANCH_DECODE_EN.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_r1,
  output logic [XLEN-1:0] out_r2,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic            out_is_branch
);

  // NOR (4'b1100) is part of the ALU encoding but never produced here.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  // entry = {r1, r2, alu_op, rd, illegal, is_branch}
  localparam int EW = 2*XLEN + 11;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic            unused_rs1_idx;

  assign opcode         = in_instr[6:0];
  assign funct3         = in_instr[14:12];
  assign funct7         = in_instr[31:25];
  assign imm_i          = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s          = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign unused_rs1_idx = ^in_instr[19:15];

  logic [XLEN-1:0] dec_r2;
  logic [3:0]      dec_op;
  logic [4:0]      dec_rd;
  logic            dec_illegal;
  logic            dec_branch;
  logic [EW-1:0]   dec_entry;

  always_comb begin
    dec_r2      = '0;
    dec_op      = OP_AND;
    dec_rd      = in_instr[11:7];
    dec_illegal = 1'b1;
    dec_branch  = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_r2 = in_rs2_val;
        if (funct7 == 7'b0000000) begin
          dec_illegal = 1'b0;
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b111:  dec_op = OP_AND;
            3'b110:  dec_op = OP_OR;
            3'b010:  dec_op = OP_SLT;
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_illegal = 1'b0;
          dec_op      = OP_SUB;
        end
      end
      7'b0010011: begin
        dec_r2      = imm_i;
        dec_illegal = 1'b0;
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b010:  dec_op = OP_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_r2      = imm_i;
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
      end
      7'b0100011: begin
        dec_r2      = imm_s;
        dec_op      = OP_ADD;
        dec_rd      = '0;
        dec_illegal = 1'b0;
      end
`ifdef ALU_BRANCH_DECODE_EN
      // BEQ: the consumer takes the branch on the ALU zero flag of rs1 - rs2.
      7'b1100011: begin
        if (funct3 == 3'b000) begin
          dec_r2      = in_rs2_val;
          dec_op      = OP_SUB;
          dec_rd      = '0;
          dec_branch  = 1'b1;
          dec_illegal = 1'b0;
        end
      end
`endif
      default: ;
    endcase
    if (dec_illegal) begin
      dec_op     = OP_AND;
      dec_r2     = '0;
      dec_branch = 1'b0;
    end
  end

  assign dec_entry = {in_rs1_val, dec_r2, dec_op, dec_rd, dec_illegal, dec_branch};

  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [EW-1:0] out_q, out_d;
  logic [EW-1:0] skid_q, skid_d;

  // in_ready comes straight from a flop so upstream never sees a combinational path.
  assign in_ready = ~skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        out_d       = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign {out_r1, out_r2, out_alu_op, out_rd, out_illegal, out_is_branch} = out_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: scoreboard of decoded entries plus per-scenario checks.
// Honours ALU_BRANCH_DECODE_EN for the BEQ expectations.
module tb_alu_issue_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_rs1_val = '0;
  logic [XLEN-1:0] in_rs2_val = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_r1;
  logic [XLEN-1:0] out_r2;
  logic [3:0]      out_alu_op;
  logic [4:0]      out_rd;
  logic            out_illegal;
  logic            out_is_branch;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r1(out_r1), .out_r2(out_r2), .out_alu_op(out_alu_op), .out_rd(out_rd),
    .out_illegal(out_illegal), .out_is_branch(out_is_branch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [3:0]      op;
    logic [4:0]      rd;
    logic            ill;
    logic            br;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_act;

  function automatic exp_t model(input logic [31:0] ins, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e.r1 = a; e.r2 = '0; e.op = 4'b0000; e.rd = ins[11:7]; e.ill = 1'b1; e.br = 1'b0;
    if (opc == 7'b0110011) begin
      if (f7 == 7'h00 && f3 == 3'b000) begin e.op = 4'b0010; e.ill = 1'b0; end
      else if (f7 == 7'h20 && f3 == 3'b000) begin e.op = 4'b0110; e.ill = 1'b0; end
      else if (f7 == 7'h00 && f3 == 3'b111) begin e.op = 4'b0000; e.ill = 1'b0; end
      else if (f7 == 7'h00 && f3 == 3'b110) begin e.op = 4'b0001; e.ill = 1'b0; end
      else if (f7 == 7'h00 && f3 == 3'b010) begin e.op = 4'b0111; e.ill = 1'b0; end
      if (!e.ill) e.r2 = b;
    end else if (opc == 7'b0010011) begin
      if (f3 == 3'b000) begin e.op = 4'b0010; e.ill = 1'b0; end
      else if (f3 == 3'b111) begin e.op = 4'b0000; e.ill = 1'b0; end
      else if (f3 == 3'b110) begin e.op = 4'b0001; e.ill = 1'b0; end
      else if (f3 == 3'b010) begin e.op = 4'b0111; e.ill = 1'b0; end
      if (!e.ill) e.r2 = {{(XLEN-12){ins[31]}}, ins[31:20]};
    end else if (opc == 7'b0000011) begin
      e.op = 4'b0010; e.ill = 1'b0; e.r2 = {{(XLEN-12){ins[31]}}, ins[31:20]};
    end else if (opc == 7'b0100011) begin
      e.op = 4'b0010; e.ill = 1'b0; e.rd = 5'd0;
      e.r2 = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
    end
`ifdef ALU_BRANCH_DECODE_EN
    else if (opc == 7'b1100011 && f3 == 3'b000) begin
      e.op = 4'b0110; e.ill = 1'b0; e.rd = 5'd0; e.br = 1'b1; e.r2 = b;
    end
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3s;
    r = $urandom;
    case (r[1:0])
      2'd0: f3s = 3'b000;
      2'd1: f3s = 3'b111;
      2'd2: f3s = 3'b110;
      default: f3s = 3'b010;
    endcase
    case ($urandom_range(0, 9))
      0: return {7'h00, r[24:15], 3'b000, r[11:7], 7'h33};
      1: return {7'h20, r[24:15], 3'b000, r[11:7], 7'h33};
      2: return {7'h00, r[24:15], f3s, r[11:7], 7'h33};
      3: return {r[31:15], f3s, r[11:7], 7'h13};
      4: return {r[31:15], 3'b010, r[11:7], 7'h03};
      5: return {r[31:15], 3'b010, r[11:7], 7'h23};
      6: return {r[31:15], 3'b000, r[11:7], 7'h63};
      7: return {7'h20, r[24:15], 3'b111, r[11:7], 7'h33};
      8: return {r[31:15], 3'b001, r[11:7], 7'h13};
      default: return r;
    endcase
  endfunction

  // Scoreboard: occupancy, head-of-queue contents while valid, pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      n_cmp++;
      if (out_valid !== (sb_q.size() > 0)) begin
        n_err++;
        $display("FAIL occ_out_valid: got %b want %b", out_valid, sb_q.size() > 0);
      end
      n_cmp++;
      if (in_ready !== (sb_q.size() < 2)) begin
        n_err++;
        $display("FAIL occ_in_ready: got %b want %b", in_ready, sb_q.size() < 2);
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid === 1'b1 && sb_q.size() > 0) begin
          mon_act = {out_r1, out_r2, out_alu_op, out_rd, out_illegal, out_is_branch};
          n_cmp++;
          if (mon_act !== sb_q[0]) begin
            n_err++;
            $display("FAIL sb_entry: got r1=%h r2=%h op=%b rd=%0d ill=%b br=%b want r1=%h r2=%h op=%b rd=%0d ill=%b br=%b",
                     mon_act.r1, mon_act.r2, mon_act.op, mon_act.rd, mon_act.ill, mon_act.br,
                     sb_q[0].r1, sb_q[0].r2, sb_q[0].op, sb_q[0].rd, sb_q[0].ill, sb_q[0].br);
          end
          if (out_ready) void'(sb_q.pop_front());
        end
        if (in_valid && in_ready) sb_q.push_back(model(in_instr, in_rs1_val, in_rs2_val));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int cnt = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_rs1_val = a;
    in_rs2_val = b;
    @(negedge clk);
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL send_timeout: in_ready got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic drain();
    int cnt = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    while (out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_timeout: out_valid got %b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_hs: got valid/ready %b%b want 01", out_valid, in_ready);
    end
    n_cmp++;
    if ({out_r1, out_r2, out_alu_op, out_rd, out_illegal, out_is_branch} !== '0) begin
      n_err++;
      $display("FAIL reset_fields: got r1=%h r2=%h op=%b rd=%0d want all 0", out_r1, out_r2, out_alu_op, out_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(32'h002081B3, 32'd5, 32'd7);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_alu_op, out_r1, out_r2, out_rd, out_illegal} !== {1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b0}) begin
      n_err++;
      $display("FAIL add: got v=%b op=%b r1=%0d r2=%0d rd=%0d ill=%b want v=1 op=0010 r1=5 r2=7 rd=3 ill=0",
               out_valid, out_alu_op, out_r1, out_r2, out_rd, out_illegal);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h402081B3; in_rs1_val = 32'd10; in_rs2_val = 32'd3;
    tick();
    in_instr = 32'hFFF00293; in_rs1_val = 32'd0; in_rs2_val = 32'd99;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_alu_op} !== {1'b1, 4'b0110}) begin
      n_err++;
      $display("FAIL b2b_sub: got v=%b op=%b want v=1 op=0110", out_valid, out_alu_op);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_alu_op, out_r2, out_rd} !== {1'b1, 4'b0010, 32'hFFFFFFFF, 5'd5}) begin
      n_err++;
      $display("FAIL b2b_addi: got v=%b op=%b r2=%h rd=%0d want v=1 op=0010 r2=ffffffff rd=5",
               out_valid, out_alu_op, out_r2, out_rd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_val = 32'd1; in_rs2_val = 32'd2;
    tick();
    in_instr = 32'hF9C0A193; in_rs1_val = 32'd3; in_rs2_val = 32'd4;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second_accept: in_ready got %b want 1", in_ready);
    end
    tick();
    in_instr = 32'h0020E1B3; in_rs1_val = 32'd5; in_rs2_val = 32'd6;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready_low: in_ready got %b want 0", in_ready);
    end
    tick();
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready_still_low: in_ready got %b want 0", in_ready);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_back: in_ready got %b want 1", in_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_illegal_flush();
    out_ready = 1'b1;
    send(32'h00000000, 32'h11, 32'h22);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_illegal, out_alu_op, out_r2, out_r1} !== {1'b1, 1'b1, 4'b0000, 32'd0, 32'h11}) begin
      n_err++;
      $display("FAIL illegal: got v=%b ill=%b op=%b r2=%h r1=%h want v=1 ill=1 op=0000 r2=0 r1=11",
               out_valid, out_illegal, out_alu_op, out_r2, out_r1);
    end
    tick();
    out_ready = 1'b0;
    send(32'h0020F1B3, 32'h1, 32'h2);
    send(32'h0020E1B3, 32'h3, 32'h4);
    in_valid = 1'b1; in_instr = 32'h002081B3; flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL flush_full_before: got valid/ready %b%b want 10", out_valid, in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_full_after: got valid/ready %b%b want 01", out_valid, in_ready);
    end
    tick();
    send(32'h002081B3, 32'h5, 32'h6);
    in_valid = 1'b1; in_instr = 32'h402081B3; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_discard_input: got valid/ready %b%b want 01", out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    send(32'h00208063, 32'd9, 32'd9);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
`ifdef ALU_BRANCH_DECODE_EN
    if ({out_valid, out_alu_op, out_is_branch, out_rd, out_illegal, out_r2} !== {1'b1, 4'b0110, 1'b1, 5'd0, 1'b0, 32'd9}) begin
      n_err++;
      $display("FAIL beq_enabled: got op=%b br=%b rd=%0d ill=%b r2=%h want op=0110 br=1 rd=0 ill=0 r2=9",
               out_alu_op, out_is_branch, out_rd, out_illegal, out_r2);
    end
`else
    if ({out_valid, out_alu_op, out_is_branch, out_illegal, out_r2} !== {1'b1, 4'b0000, 1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL beq_disabled: got op=%b br=%b ill=%b r2=%h want op=0000 br=0 ill=1 r2=0",
               out_alu_op, out_is_branch, out_illegal, out_r2);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_instr   = rand_instr();
      in_rs1_val = $urandom;
      in_rs2_val = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 40) == 0);
      tick();
    end
    flush = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h7, 32'h8);
    send(32'h402081B3, 32'h9, 32'hA);
    in_valid = 1'b1; in_instr = 32'h0020E1B3;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL midreset_hs: got valid/ready %b%b want 01", out_valid, in_ready);
    end
    n_cmp++;
    if ({out_r1, out_r2, out_alu_op, out_rd, out_illegal, out_is_branch} !== '0) begin
      n_err++;
      $display("FAIL midreset_fields: got r1=%h r2=%h op=%b rd=%0d want all 0", out_r1, out_r2, out_alu_op, out_rd);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(32'h002081B3, 32'd20, 32'd22);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_alu_op, out_r1, out_r2, out_rd} !== {1'b1, 4'b0010, 32'd20, 32'd22, 5'd3}) begin
      n_err++;
      $display("FAIL midreset_after: got v=%b op=%b r1=%0d r2=%0d rd=%0d want v=1 op=0010 r1=20 r2=22 rd=3",
               out_valid, out_alu_op, out_r1, out_r2, out_rd);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_illegal_flush();
    test_beq();
    test_random();
    test_reset_mid();
    drain();
    @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
